// File: rtl/async_fifo_read_stream.sv
// Read-domain consumer for the async FIFO: pops with credit-based flow control
// and re-times the registered FIFO read data into a valid/ready stream.
module async_fifo_read_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             read_clk,
  input  logic                             read_rst,
  input  logic                             p_read_empty,
  output logic                             p_read_en,
  input  logic [DATA_WIDTH-1:0]            p_read_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [CNT_WIDTH-1:0]             word_count,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_level
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(BUF_DEPTH);
  localparam logic [LW:0] DEPTH_C = (LW + 1)'(BUF_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [LW-1:0]         count;
  logic                  inflight;
  logic [IW-1:0]         head;
  logic [IW-1:0]         tail;
  logic                  pop;
  logic                  accept;
  logic [LW:0]           credit;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign pop    = (count != '0) && m_ready;
  // Occupancy after this edge, counting the word still in flight
  assign credit = {1'b0, count}
                + {{LW{1'b0}}, inflight}
                - {{LW{1'b0}}, pop};

  assign p_read_en = !read_rst && !p_read_empty
                   && (credit < DEPTH_C);
  assign accept    = p_read_en && !p_read_empty;

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      mem        <= '{default: '0};
      count      <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      word_count <= '0;
    end else begin
      inflight <= accept;
      count    <= credit[LW-1:0];
      if (inflight) begin
        mem[tail] <= p_read_data;
        tail      <= idx_inc(tail);
      end
      if (pop) begin
        head       <= idx_inc(head);
        word_count <= word_count + 1'b1;
      end
    end
  end

  assign m_valid   = (count != '0);
  assign m_data    = mem[head];
  assign buf_level = count;

endmodule
